// File: rtl/imem_fetch_sequencer.sv
// Fetch-side controller for the multicycle CPU: owns the PC, latches the
// instruction register and computes the next PC when execute retires an instruction.
module imem_fetch_sequencer #(
    parameter logic [15:0] RESET_PC    = 16'd0,
    parameter logic [5:0]  JUMP_OP     = 6'b000001,
    parameter bit          HALT_ON_NOP = 1'b1,
    parameter int          CNT_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic [15:0]      imem_pc,
    input  logic [31:0]      imem_instr,
    output logic [31:0]      ir,
    output logic             ir_valid,
    input  logic             instr_done,
    input  logic             br_taken,
    output logic [15:0]      pc,
    output logic             halted,
    output logic [CNT_W-1:0] instr_count
);

    typedef enum logic [1:0] {
        IDLE,
        FETCH,
        EXEC,
        HALT
    } state_t;

    state_t           r_state;
    state_t           w_nextState;
    logic [15:0]      r_pc;
    logic [15:0]      w_nextPc;
    logic [31:0]      r_ir;
    logic [31:0]      w_nextIr;
    logic             r_irValid;
    logic             w_nextIrValid;
    logic             r_halted;
    logic             w_nextHalted;
    logic [CNT_W-1:0] r_count;
    logic [CNT_W-1:0] w_nextCount;
    logic [15:0]      w_offset;
    logic [15:0]      w_target;
    logic             w_isJump;
    logic             w_isBranch;

    // The 16-bit offset needs no extension at 16-bit PC width; the add wraps naturally.
    assign w_offset   = r_ir[15:0];
    assign w_target   = r_pc + 16'd1 + w_offset;
    assign w_isJump   = (r_ir[31:26] == JUMP_OP);
    assign w_isBranch = (r_ir[31:30] == 2'b10);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state   <= IDLE;
            r_pc      <= RESET_PC;
            r_ir      <= 32'h0;
            r_irValid <= 1'b0;
            r_halted  <= 1'b0;
            r_count   <= '0;
        end else begin
            r_state   <= w_nextState;
            r_pc      <= w_nextPc;
            r_ir      <= w_nextIr;
            r_irValid <= w_nextIrValid;
            r_halted  <= w_nextHalted;
            r_count   <= w_nextCount;
        end
    end

    always_comb begin
        w_nextState   = r_state;
        w_nextPc      = r_pc;
        w_nextIr      = r_ir;
        w_nextIrValid = r_irValid;
        w_nextHalted  = r_halted;
        w_nextCount   = r_count;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_nextState = FETCH;
                end
            end
            FETCH: begin
                w_nextIr = imem_instr;
                if (HALT_ON_NOP && (imem_instr == 32'h0)) begin
                    w_nextState  = HALT;
                    w_nextHalted = 1'b1;
                end else begin
                    w_nextState   = EXEC;
                    w_nextIrValid = 1'b1;
                end
            end
            EXEC: begin
                if (instr_done) begin
                    // br_taken only matters for the branch class; jumps are unconditional.
                    if (w_isJump || (w_isBranch && br_taken)) begin
                        w_nextPc = w_target;
                    end else begin
                        w_nextPc = r_pc + 16'd1;
                    end
                    w_nextIrValid = 1'b0;
                    if (r_count != '1) begin
                        w_nextCount = r_count + CNT_W'(1);
                    end
                    w_nextState = FETCH;
                end
            end
            HALT: begin
                w_nextHalted  = 1'b1;
                w_nextIrValid = 1'b0;
            end
        endcase
    end

    assign imem_pc     = r_pc;
    assign pc          = r_pc;
    assign ir          = r_ir;
    assign ir_valid    = r_irValid;
    assign halted      = r_halted;
    assign instr_count = r_count;

endmodule

// File: tb/tb_imem_fetch_sequencer.sv
// Randomized bench for imem_fetch_sequencer against a transaction-level PC/count model,
// plus a second instance covering NOOP execution, PC wrap and counter saturation.
module tb_imem_fetch_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        instrDone;
    logic        brTaken;
    logic [15:0] imemPc;
    logic [31:0] imemInstr;
    logic [31:0] ir;
    logic        irValid;
    logic [15:0] pc;
    logic        halted;
    logic [15:0] instrCount;

    logic        altStart;
    logic        altDone;
    logic        altBr;
    logic [15:0] altImemPc;
    logic [31:0] altInstr;
    logic [31:0] altIr;
    logic        altIrValid;
    logic [15:0] altPc;
    logic        altHalted;
    logic [1:0]  altCount;

    logic [31:0] mem [0:65535];

    int          checks = 0;
    int          failures = 0;
    logic [15:0] expPc;
    int          expCount;
    bit          expHalted;

    logic [31:0] altWords [4] = '{32'h0000_0000, 32'h1234_5678, 32'h8000_FFFD, 32'h0000_0000};
    logic        altBrs   [4] = '{1'b0, 1'b0, 1'b1, 1'b0};
    logic [15:0] altPcs   [4] = '{16'h0000, 16'h0001, 16'hFFFF, 16'h0000};
    logic [1:0]  altCnts  [4] = '{2'd1, 2'd2, 2'd3, 2'd3};

    always #5 clk = ~clk;

    assign imemInstr = mem[imemPc];

    imem_fetch_sequencer dut (
        .clk         (clk),
        .rst         (rst),
        .start       (start),
        .imem_pc     (imemPc),
        .imem_instr  (imemInstr),
        .ir          (ir),
        .ir_valid    (irValid),
        .instr_done  (instrDone),
        .br_taken    (brTaken),
        .pc          (pc),
        .halted      (halted),
        .instr_count (instrCount)
    );

    imem_fetch_sequencer #(
        .RESET_PC    (16'hFFFF),
        .HALT_ON_NOP (1'b0),
        .CNT_W       (2)
    ) dutAlt (
        .clk         (clk),
        .rst         (rst),
        .start       (altStart),
        .imem_pc     (altImemPc),
        .imem_instr  (altInstr),
        .ir          (altIr),
        .ir_valid    (altIrValid),
        .instr_done  (altDone),
        .br_taken    (altBr),
        .pc          (altPc),
        .halted      (altHalted),
        .instr_count (altCount)
    );

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%h expected=%h at %0t", tag, got, exp, $time);
        end
    endtask

    // Next PC from the ISA rules using signed integer arithmetic reduced modulo 2^16.
    function automatic logic [15:0] modelNext(input logic [15:0] curPc, input logic [31:0] word,
                                              input logic taken);
        int offset;
        int dest;
        offset = int'($signed(word[15:0]));
        if ((word[31:26] == 6'b000001) || ((word[31:30] == 2'b10) && taken))
            dest = int'(curPc) + 1 + offset;
        else
            dest = int'(curPc) + 1;
        dest = ((dest % 65536) + 65536) % 65536;
        return 16'(dest);
    endfunction

    function automatic logic [31:0] randomWord();
        logic [31:0] word;
        case ($urandom_range(0, 15))
            0, 1, 2, 3:     word = {6'b000001, 10'($urandom), 16'($urandom)};
            4, 5, 6, 7, 8:  word = {2'b10, 14'($urandom), 16'($urandom)};
            9:              word = 32'h0;
            default:        word = $urandom;
        endcase
        return word;
    endfunction

    // Runs one instruction; entered #1 after the edge that put the DUT into FETCH.
    task automatic applyStimulus(input logic [31:0] word, input logic taken, input int waitCycles);
        mem[expPc] = word;
        checkOutput("fetchPc", {16'h0, imemPc}, {16'h0, expPc});
        checkOutput("fetchIrValid", {31'h0, irValid}, 32'h0);
        start = 1'($urandom_range(0, 1));
        @(posedge clk); #1;
        start = 1'b0;
        if (word == 32'h0) begin
            expHalted = 1'b1;
            checkOutput("haltEntry", {14'h0, halted, irValid, pc}, {14'h0, 1'b1, 1'b0, expPc});
            checkOutput("haltCount", {16'h0, instrCount}, expCount);
            return;
        end
        checkOutput("irLatch", ir, word);
        checkOutput("execState", {15'h0, irValid, pc}, {15'h0, 1'b1, expPc});
        repeat (waitCycles) begin
            start   = 1'($urandom_range(0, 1));
            brTaken = 1'($urandom_range(0, 1));
            @(posedge clk); #1;
            checkOutput("execHold", {15'h0, irValid, pc}, {15'h0, 1'b1, expPc});
        end
        start     = 1'($urandom_range(0, 1));
        instrDone = 1'b1;
        brTaken   = taken;
        @(posedge clk); #1;
        instrDone = 1'b0;
        start     = 1'b0;
        brTaken   = 1'b0;
        expPc = modelNext(expPc, word, taken);
        if (expCount < 65535) expCount++;
        checkOutput("retirePc", {16'h0, pc}, {16'h0, expPc});
        checkOutput("retireCount", {16'h0, instrCount}, expCount);
        checkOutput("retireIrValid", {31'h0, irValid}, 32'h0);
    endtask

    // Confirms HALT ignores start/instr_done, then resets asynchronously and restarts.
    task automatic haltAndReset();
        repeat (3) begin
            start     = 1'b1;
            instrDone = 1'b1;
            brTaken   = 1'b1;
            @(posedge clk); #1;
            start     = 1'b0;
            instrDone = 1'b0;
            brTaken   = 1'b0;
            checkOutput("haltFrozen", {14'h0, halted, irValid, pc}, {14'h0, 1'b1, 1'b0, expPc});
            checkOutput("haltFrozenCount", {16'h0, instrCount}, expCount);
        end
        rst = 1'b1;
        #1;
        checkOutput("haltReset", {14'h0, halted, irValid, pc}, 32'h0);
        @(posedge clk); #1;
        rst = 1'b0;
        expPc     = 16'h0;
        expCount  = 0;
        expHalted = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog expired got=running expected=finished");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        logic [15:0] altExp;
        int          altCnt;
        rst       = 1'b1;
        start     = 1'b0;
        instrDone = 1'b0;
        brTaken   = 1'b0;
        altStart  = 1'b0;
        altDone   = 1'b0;
        altBr     = 1'b0;
        altInstr  = 32'h0;
        expPc     = 16'h0;
        expCount  = 0;
        expHalted = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        checkOutput("resetPc", {16'h0, pc}, 32'h0);
        checkOutput("resetIr", ir, 32'h0);
        checkOutput("resetFlags", {29'h0, irValid, halted, 1'b0}, 32'h0);
        checkOutput("resetCount", {16'h0, instrCount}, 32'h0);
        checkOutput("resetAltPc", {16'h0, altPc}, 32'h0000_FFFF);

        instrDone = 1'b1;
        @(posedge clk); #1;
        instrDone = 1'b0;
        @(posedge clk); #1;
        checkOutput("idleIgnoresDone", {15'h0, irValid, pc}, 32'h0);
        checkOutput("idleCount", {16'h0, instrCount}, 32'h0);

        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;

        applyStimulus(32'hE400_FFFF, 1'b0, 1);
        checkOutput("plainPc", {16'h0, pc}, 32'd1);
        applyStimulus(32'h0400_000A, 1'b0, 0);
        checkOutput("jumpPc", {16'h0, pc}, 32'd12);
        applyStimulus(32'h87F7_FFFD, 1'b1, 2);
        checkOutput("bneTakenPc", {16'h0, pc}, 32'd10);
        applyStimulus(32'h0400_0001, 1'b0, 0);
        applyStimulus(32'h87F7_FFFD, 1'b0, 0);
        checkOutput("bneNotTakenPc", {16'h0, pc}, 32'd13);
        applyStimulus(32'hC800_0005, 1'b1, 0);
        checkOutput("addiIgnoresBr", {16'h0, pc}, 32'd14);
        applyStimulus(32'h0400_0002, 1'b0, 0);
        checkOutput("jumpFwdPc", {16'h0, pc}, 32'd17);
        applyStimulus(32'h0, 1'b0, 0);
        checkOutput("nopHaltPc", {15'h0, halted, pc}, {15'h0, 1'b1, 16'd17});

        for (int n = 0; n < 300; n++) begin
            if (expHalted) haltAndReset();
            applyStimulus(randomWord(), 1'($urandom_range(0, 1)), $urandom_range(0, 3));
        end
        if (expHalted) haltAndReset();

        mem[expPc] = 32'h1234_5678;
        @(posedge clk); #1;
        instrDone = 1'b1;
        #2;
        rst = 1'b1;
        #1;
        checkOutput("asyncResetPc", {16'h0, pc}, 32'h0);
        checkOutput("asyncResetIr", ir, 32'h0);
        checkOutput("asyncResetFlags", {30'h0, irValid, halted}, 32'h0);
        checkOutput("asyncResetCount", {16'h0, instrCount}, 32'h0);
        @(posedge clk); #1;
        instrDone = 1'b0;
        rst = 1'b0;
        @(posedge clk); #1;
        checkOutput("afterAsyncReset", {15'h0, irValid, pc}, 32'h0);
        checkOutput("pendingDoneDropped", {16'h0, instrCount}, 32'h0);

        altExp = 16'hFFFF;
        altCnt = 0;
        altStart = 1'b1;
        @(posedge clk); #1;
        altStart = 1'b0;
        for (int i = 0; i < 4; i++) begin
            altInstr = altWords[i];
            checkOutput("altFetchPc", {16'h0, altImemPc}, {16'h0, altExp});
            @(posedge clk); #1;
            checkOutput("altIr", altIr, altWords[i]);
            checkOutput("altExec", {30'h0, altIrValid, altHalted}, 32'd2);
            altDone = 1'b1;
            altBr   = altBrs[i];
            @(posedge clk); #1;
            altDone = 1'b0;
            altBr   = 1'b0;
            altExp = modelNext(altExp, altWords[i], altBrs[i]);
            if (altCnt < 3) altCnt++;
            checkOutput("altPcModel", {16'h0, altPc}, {16'h0, altExp});
            checkOutput("altPcTable", {16'h0, altPc}, {16'h0, altPcs[i]});
            checkOutput("altCountModel", {30'h0, altCount}, altCnt);
            checkOutput("altCountTable", {30'h0, altCount}, {30'h0, altCnts[i]});
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
